// File: rtl/alu_rot_seq.sv
// Bit-serial 16-bit rotate/shift unit: one bit per cycle, result valid amt+1 cycles after accept.
// Backpressure: the result is held in DONE until out_ready; no new request is taken until then.
module alu_rot_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] src,
   input  logic [3:0]  amt,
   input  logic [1:0]  op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] res,
   output logic        carry,
   output logic        zero
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [1:0] OP_ROL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_SLL = 2'b11;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [1:0]  op_q;
   logic [15:0] step_res;
   logic        step_carry;

   // res doubles as the working register, so it is stable whenever the FSM is not shifting
   always_comb begin
      step_res   = res;
      step_carry = 1'b0;
      case (op_q)
         OP_ROL: begin
            step_res   = {res[14:0], res[15]};
            step_carry = res[15];
         end
         OP_SRL: begin
            step_res   = {1'b0, res[15:1]};
            step_carry = res[0];
         end
         OP_SRA: begin
            step_res   = {res[15], res[15:1]};
            step_carry = res[0];
         end
         OP_SLL: begin
            step_res   = {res[14:0], 1'b0};
            step_carry = res[15];
         end
         default: begin
            step_res   = res;
            step_carry = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         res   <= 16'h0000;
         carry <= 1'b0;
         cnt   <= 4'd0;
         op_q  <= OP_ROL;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  res   <= src;
                  cnt   <= amt;
                  op_q  <= op;
                  carry <= 1'b0;
                  state <= (amt == 4'd0) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               res   <= step_res;
               carry <= step_carry;
               cnt   <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign zero      = (res == 16'h0000);

endmodule
